serial_alu: RTL and testbench
=============================

Name: serial_alu

Overview:
Parametrised multi-cycle successor to the single-bit ALU slice. It latches two WIDTH-bit operands, an opcode and a carry-in, then evaluates SLICE bits per clock, LSB first, with an internal carry/borrow chain. It returns a registered result with carry, zero and negative flags over a valid/ready handshake. It sits between the operand register file and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of SLICE.
SLICE, 1, bits processed per clock; legal values 1, 2, 4, WIDTH.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request carries a valid operation
in_ready  out  1  block can accept a request
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (ADD) / borrow-in (SUB)
alu_sel  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 PASS A, 110 PASS B, 111 NOT A
out_valid  out  1  result and flags are valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
cout  out  1  carry-out (ADD) / borrow-out (SUB); 0 for all other ops
zero  out  1  result == 0
neg  out  1  result[WIDTH-1]
ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low (rst_n), single clock clk.
- Reset state: IDLE. All of the following are 0: in_ready, out_valid, result, cout, zero, neg, ovf, and every internal register. in_ready rises on the first clk edge after rst_n deasserts.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b, cin, alu_sel; clear the slice counter; load the carry chain with cin (ADD) or cin as borrow (SUB).
  - Go to RUN.
- RUN:
  - in_ready=0.
  - Each clock, compute slice k = bits [k*SLICE +: SLICE] and write it into the result shift/accumulate register. The carry/borrow from slice k feeds slice k+1.
  - After N = WIDTH/SLICE slices, go to DONE. out_valid is asserted exactly N clocks after the accepting edge.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready=1: out_valid drops the next edge and the FSM goes to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap. Minimum issue interval is N+2 clocks.
- Arithmetic:
  - ADD: {cout,result} = a + b + cin.
  - SUB: result = a - b - cin mod 2^WIDTH; cout = 1 iff a < b + cin unsigned (borrow).
  - Logic, pass and NOT ops: cout=0; cin is ignored.
- Flags:
  - zero is computed over the full WIDTH-bit final result.
  - neg = result MSB.
  - Flags become valid together with out_valid.
- Request handling:
  - in_valid while in_ready=0 is ignored; the requester must hold the request.
  - Operand changes after the accepting edge do not affect the current operation.
- Output register contents:
  - The result register updates only when DONE is entered. Between operations it keeps the last result.
  - Consumers qualify result with out_valid.
- Reset mid-operation (RUN or DONE): the operation is abandoned without output and everything returns to reset values.
- Undefined alu_sel values cannot occur (3-bit, fully decoded).

Optional Feature:
Macro ALU_OVF_FLAG_EN.
- Defined: ovf = signed two's-complement overflow, registered at DONE entry.
  - ADD: ovf = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - SUB: ovf = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - All other ops: ovf = 0.
- Not defined: the ovf port remains and is tied to constant 0; no overflow logic is synthesised.

Test Plan:
- WIDTH=8, SLICE=1: ADD a=0xFF, b=0x01, cin=0 -> out_valid 8 clks after accept; result=0x00, cout=1, zero=1, neg=0.
- SUB a=0x10, b=0x20, cin=1 -> result=0xEF, cout=1, neg=1, zero=0. Then XOR a=0xA5, b=0xA5 -> result=0x00, zero=1, cout=0.
- Backpressure: hold out_ready=0 for 5 clks after out_valid -> result and flags stable, in_ready=0 throughout. A second in_valid is not accepted until one clk after out_ready handshake.
- Reset mid-RUN: drop rst_n at slice 3 of ADD -> out_valid, result and flags go to 0 immediately (async). After release, no stale out_valid; a new request completes normally.
- WIDTH=8, SLICE=4: ADD a=0x0F, b=0x01 -> out_valid 2 clks after accept; result=0x10, cout=0. NOT A a=0x3C -> 0xC3, neg=1.
- With ALU_OVF_FLAG_EN: ADD 0x7F+0x01 -> result=0x80, ovf=1; SUB 0x80-0x01 -> 0x7F, ovf=1. Without the macro, ovf=0 for both.

Source files
------------

// File: rtl/serial_alu.sv
// serial_alu: multi-cycle ALU that evaluates SLICE bits per clock, LSB first,
// carrying an internal carry/borrow chain between slices. It takes requests
// over a valid/ready handshake and returns the result and flags the same way.
// Optional feature: define ALU_OVF_FLAG_EN to compute the signed overflow flag;
// without it the ovf port is tied to 0.
module serial_alu #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_PASA = 3'b101;
  localparam logic [2:0] OP_PASB = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  logic [1:0]       r_state;
  logic             r_inReady;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_neg;

  logic             w_accept;
  logic             w_lastSlice;
  logic [SLICE-1:0] w_aSlice;
  logic [SLICE-1:0] w_bSlice;
  logic [SLICE:0]   w_sum;
  logic [SLICE:0]   w_diff;
  logic [SLICE-1:0] w_slice;
  logic             w_carryNext;
  logic [WIDTH-1:0] w_accNext;

  assign w_accept    = (r_state == ST_IDLE) && in_valid && r_inReady;
  assign w_lastSlice = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
  assign w_aSlice    = r_a[SLICE-1:0];
  assign w_bSlice    = r_b[SLICE-1:0];
  assign w_sum       = {1'b0, w_aSlice} + {1'b0, w_bSlice} + {{SLICE{1'b0}}, r_carry};
  assign w_diff      = {1'b0, w_aSlice} - {1'b0, w_bSlice} - {{SLICE{1'b0}}, r_carry};

  // Evaluate the current slice; only ADD/SUB propagate a carry/borrow
  always_comb begin
    w_slice     = '0;
    w_carryNext = 1'b0;
    case (r_op)
      OP_AND:  w_slice = w_aSlice & w_bSlice;
      OP_OR:   w_slice = w_aSlice | w_bSlice;
      OP_XOR:  w_slice = w_aSlice ^ w_bSlice;
      OP_ADD: begin
        w_slice     = w_sum[SLICE-1:0];
        w_carryNext = w_sum[SLICE];
      end
      OP_SUB: begin
        w_slice     = w_diff[SLICE-1:0];
        w_carryNext = w_diff[SLICE];
      end
      OP_PASA: w_slice = w_aSlice;
      OP_PASB: w_slice = w_bSlice;
      OP_NOTA: w_slice = ~w_aSlice;
      default: w_slice = '0;
    endcase
  end

  // New slices enter at the top so the LSB slice ends up at bit 0 after N steps
  assign w_accNext = (r_acc >> SLICE) | (WIDTH'(w_slice) << (WIDTH - SLICE));

  // Sequencing: in_ready is registered so it rises one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_inReady <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_inReady <= 1'b1;
          r_cnt     <= '0;
          if (w_accept) begin
            r_state   <= ST_RUN;
            r_inReady <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_lastSlice) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            r_inReady <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_inReady <= 1'b0;
        end
      endcase
    end
  end

  // Operand shifters, carry chain and partial-result accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= alu_sel;
      r_carry <= cin;
      r_acc   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> SLICE;
      r_b     <= r_b >> SLICE;
      r_carry <= w_carryNext;
      r_acc   <= w_accNext;
    end
  end

  // Visible result and flags change only when the last slice completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_lastSlice) begin
      r_result <= w_accNext;
      r_cout   <= w_carryNext;
      r_zero   <= (w_accNext == '0);
      r_neg    <= w_accNext[WIDTH-1];
    end
  end

`ifdef ALU_OVF_FLAG_EN
  logic r_aMsb;
  logic r_bMsb;
  logic r_ovf;

  // Operand sign bits are kept aside because the shifters consume them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aMsb <= 1'b0;
      r_bMsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_aMsb <= a[WIDTH-1];
        r_bMsb <= b[WIDTH-1];
      end
      if (w_lastSlice) begin
        case (r_op)
          OP_ADD:  r_ovf <= (r_aMsb == r_bMsb) && (w_accNext[WIDTH-1] != r_aMsb);
          OP_SUB:  r_ovf <= (r_aMsb != r_bMsb) && (w_accNext[WIDTH-1] != r_aMsb);
          default: r_ovf <= 1'b0;
        endcase
      end
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = r_inReady;
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed vectors applied to a SLICE=1 and a SLICE=4 instance
// of serial_alu, plus hand-written backpressure and mid-operation reset sequences.
module tb_serial_alu;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a, b;
  logic       cin;
  logic [2:0] alu_sel;

  logic       inValid1, inReady1, outValid1, outReady1, cout1, zero1, neg1, ovf1;
  logic [7:0] result1;
  logic       inValid4, inReady4, outValid4, outReady4, cout4, zero4, neg4, ovf4;
  logic [7:0] result4;

  int         curDut;
  logic       selInReady, selOutValid, selCout, selZero, selNeg, selOvf;
  logic [7:0] selResult;

  int compared   = 0;
  int mismatched = 0;

  serial_alu #(.WIDTH(8), .SLICE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1),
    .a(a), .b(b), .cin(cin), .alu_sel(alu_sel),
    .out_valid(outValid1), .out_ready(outReady1), .result(result1),
    .cout(cout1), .zero(zero1), .neg(neg1), .ovf(ovf1)
  );

  serial_alu #(.WIDTH(8), .SLICE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4),
    .a(a), .b(b), .cin(cin), .alu_sel(alu_sel),
    .out_valid(outValid4), .out_ready(outReady4), .result(result4),
    .cout(cout4), .zero(zero4), .neg(neg4), .ovf(ovf4)
  );

  // Route the currently selected instance's outputs to common names
  always_comb begin
    if (curDut == 0) begin
      selInReady = inReady1; selOutValid = outValid1; selResult = result1;
      selCout = cout1; selZero = zero1; selNeg = neg1; selOvf = ovf1;
    end else begin
      selInReady = inReady4; selOutValid = outValid4; selResult = result4;
      selCout = cout4; selZero = zero4; selNeg = neg4; selOvf = ovf4;
    end
  end

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setValid(input logic v);
    if (curDut == 0) inValid1 = v; else inValid4 = v;
  endtask

  task automatic setOutReady(input logic v);
    if (curDut == 0) outReady1 = v; else outReady4 = v;
  endtask

  function automatic logic expectOvf(input logic v);
`ifdef ALU_OVF_FLAG_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkResults(input string tag, input vec_t v);
    checkOutput({tag, "_result"}, 32'(selResult), 32'(v.res));
    checkOutput({tag, "_cout"},   32'(selCout),   32'(v.cout));
    checkOutput({tag, "_zero"},   32'(selZero),   32'(v.zero));
    checkOutput({tag, "_neg"},    32'(selNeg),    32'(v.neg));
    checkOutput({tag, "_ovf"},    32'(selOvf),    32'(expectOvf(v.ovf)));
  endtask

  // Counts edges from the current point until out_valid is seen (bounded)
  task automatic waitOutValid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!selOutValid && lat < 50);
  endtask

  task automatic applyStimulus(input string tag, input vec_t v, input int expLat);
    int waited;
    int lat;
    waited = 0;
    while (!selInReady && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!selInReady) begin
      checkOutput({tag, "_ready_timeout"}, 32'(selInReady), 32'd1);
      return;
    end
    a = v.a; b = v.b; cin = v.cin; alu_sel = v.op;
    setValid(1'b1);
    @(posedge clk); #1;
    setValid(1'b0);
    a = ~v.a; b = ~v.b; cin = ~v.cin; alu_sel = ~v.op;
    waitOutValid(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkResults(tag, v);
    setOutReady(1'b1);
    @(posedge clk); #1;
    setOutReady(1'b0);
    checkOutput({tag, "_valid_drop"}, 32'(selOutValid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(selInReady), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    logic sawValid;
    vec_t bp1, bp2, after;

    //            op      a      b      cin   res    cout  zero  neg   ovf
    vecs[0]  = '{3'b011, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'b100, 8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b010, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 8'h81, 8'h22, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'b110, 8'h81, 8'h7E, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 8'h3C, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'b011, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{3'b100, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'b011, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b100, 8'h20, 8'h1F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'b000, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'b100, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{3'b011, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'b011, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; alu_sel = '0;
    inValid1 = 1'b0; outReady1 = 1'b0; inValid4 = 1'b0; outReady4 = 1'b0;
    curDut = 0;

    // Reset state of both instances
    #12;
    for (int d = 0; d < 2; d++) begin
      curDut = d; #1;
      checkOutput($sformatf("rst_dut%0d_in_ready", d),  32'(selInReady),  32'd0);
      checkOutput($sformatf("rst_dut%0d_out_valid", d), 32'(selOutValid), 32'd0);
      checkOutput($sformatf("rst_dut%0d_result", d),    32'(selResult),   32'd0);
      checkOutput($sformatf("rst_dut%0d_flags", d),
                  32'({selCout, selZero, selNeg, selOvf}), 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    curDut = 0; #1;
    checkOutput("rel_in_ready_before_edge", 32'(selInReady), 32'd0);
    @(posedge clk); #1;
    checkOutput("rel_in_ready_after_edge", 32'(selInReady), 32'd1);

    // Table-driven vectors on both slice widths
    for (int d = 0; d < 2; d++) begin
      curDut = d; #1;
      for (int i = 0; i < 16; i++) begin
        applyStimulus($sformatf("v%0d_dut%0d", i, d), vecs[i], (d == 0) ? 8 : 2);
      end
    end

    // Backpressure: result held while out_ready=0, queued request waits
    curDut = 0; #1;
    bp1 = '{3'b011, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
    bp2 = '{3'b010, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    a = bp1.a; b = bp1.b; cin = bp1.cin; alu_sel = bp1.op;
    inValid1 = 1'b1;
    @(posedge clk); #1;
    a = bp2.a; b = bp2.b; cin = bp2.cin; alu_sel = bp2.op;
    checkOutput("bp_in_ready_run", 32'(selInReady), 32'd0);
    waitOutValid(lat);
    checkOutput("bp_latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold%0d_valid", k), 32'(selOutValid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_in_ready", k), 32'(selInReady), 32'd0);
      checkResults($sformatf("bp_hold%0d", k), bp1);
    end
    outReady1 = 1'b1;
    @(posedge clk); #1;
    outReady1 = 1'b0;
    checkOutput("bp_hs_valid_drop", 32'(selOutValid), 32'd0);
    checkOutput("bp_hs_in_ready", 32'(selInReady), 32'd1);
    @(posedge clk); #1;
    inValid1 = 1'b0;
    checkOutput("bp_second_accepted", 32'(selInReady), 32'd0);
    waitOutValid(lat);
    checkOutput("bp2_latency", 32'(lat), 32'd8);
    checkResults("bp2", bp2);
    outReady1 = 1'b1;
    @(posedge clk); #1;
    outReady1 = 1'b0;

    // Reset in the middle of RUN
    a = 8'h01; b = 8'h02; cin = 1'b0; alu_sel = 3'b011;
    inValid1 = 1'b1;
    @(posedge clk); #1;
    inValid1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", 32'(selOutValid), 32'd0);
    checkOutput("mrst_result",    32'(selResult),   32'd0);
    checkOutput("mrst_flags",     32'({selCout, selZero, selNeg, selOvf}), 32'd0);
    checkOutput("mrst_in_ready",  32'(selInReady),  32'd0);
    curDut = 1; #1;
    checkOutput("mrst_dut4_result", 32'(selResult), 32'd0);
    curDut = 0; #1;
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (selOutValid) sawValid = 1'b1;
    end
    checkOutput("mrst_no_stale_valid", 32'(sawValid), 32'd0);
    after = '{3'b011, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus("mrst_after", after, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
